// File: rtl/mygo_chan_sum_reader_if.sv
// rtl/mygo_chan_sum_reader_if.sv - command, FIFO-pop and result channels of the sum reader
// res_ovf exists only when MYGO_SUM_READER_OVF_EN is defined.
interface mygo_chan_sum_reader_if #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 16
);
  logic [CNT_BITS-1:0] cmd_data;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    res_data;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
`ifdef MYGO_SUM_READER_OVF_EN
  logic                res_ovf;
`endif

  modport slave (
    input  cmd_data, cmd_valid, in_data, in_valid, res_ready,
    output cmd_ready, in_ready, res_data, res_valid, busy
`ifdef MYGO_SUM_READER_OVF_EN
    , output res_ovf
`endif
  );

  modport master (
    output cmd_data, cmd_valid, in_data, in_valid, res_ready,
    input  cmd_ready, in_ready, res_data, res_valid, busy
`ifdef MYGO_SUM_READER_OVF_EN
    , input res_ovf
`endif
  );
endinterface

// File: rtl/mygo_chan_sum_reader.sv
// rtl/mygo_chan_sum_reader.sv - drains n words from a FIFO, returns their modular sum
// Optional sticky carry flag res_ovf under MYGO_SUM_READER_OVF_EN.
module mygo_chan_sum_reader #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 16
) (
  input logic                   clk,
  input logic                   rst,
  mygo_chan_sum_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, EMIT} state_t;

  state_t              state;
  logic [WIDTH-1:0]    acc;
  logic [CNT_BITS-1:0] remaining;
  logic [WIDTH-1:0]    sum;
  logic                beat;
  logic                cmd_ready_q;
  logic                in_ready_q;
  logic                res_valid_q;
  logic [WIDTH-1:0]    res_data_q;
  logic                busy_q;

`ifdef MYGO_SUM_READER_OVF_EN
  logic carry;
  logic ovf;
  always_comb {carry, sum} = {1'b0, acc} + {1'b0, bus.in_data};
  assign bus.res_ovf = ovf;
`else
  always_comb sum = acc + bus.in_data;
`endif

  assign beat          = bus.in_valid & in_ready_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;

  // All handshake outputs are registered so no input reaches a ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      remaining   <= '0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef MYGO_SUM_READER_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            remaining   <= bus.cmd_data;
            acc         <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef MYGO_SUM_READER_OVF_EN
            ovf         <= 1'b0;
`endif
            if (bus.cmd_data != '0) begin
              state      <= RECV;
              in_ready_q <= 1'b1;
            end else begin
              state       <= EMIT;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
            end
          end
        end
        RECV: begin
          if (beat) begin
            acc       <= sum;
            remaining <= remaining - CNT_BITS'(1);
`ifdef MYGO_SUM_READER_OVF_EN
            if (carry) ovf <= 1'b1;
`endif
            if (remaining == CNT_BITS'(1)) begin
              state       <= EMIT;
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              res_data_q  <= sum;
            end
          end
        end
        EMIT: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mygo_chan_sum_reader.sv
// tb/tb_mygo_chan_sum_reader.sv - directed bench with a FIFO model and a spec-level sum scoreboard
module tb_mygo_chan_sum_reader;
  localparam int W  = 32;
  localparam int CB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mygo_chan_sum_reader_if #(.WIDTH(W), .CNT_BITS(CB)) bus ();
  mygo_chan_sum_reader #(.WIDTH(W), .CNT_BITS(CB)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] fifo_q[$];
  logic        gate = 1'b0;
  int          pops_total = 0;
  int          ir_cnt = 0;
  logic        pop, hs_cmd, hs_res;
  logic [31:0] got_res;
  logic        got_ovf;
  logic [31:0] tmp;

  bit              m_cmd_ready = 1'b0;
  int              m_pops_left = 0;
  bit              m_emit = 1'b0;
  logic [31:0]     m_res = '0;
  bit              m_ovf = 1'b0;
  longint unsigned m_tot;
  int              m_n;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic refresh();
    bus.in_valid = gate && (fifo_q.size() > 0);
    bus.in_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // Model: a command snapshots the sum of the next n FIFO words; n pops then one result.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_busy", bus.busy, 0);
`ifdef MYGO_SUM_READER_OVF_EN
      check("rst_res_ovf", bus.res_ovf, 0);
`endif
      m_cmd_ready = 1'b0;
      m_pops_left = 0;
      m_emit      = 1'b0;
    end else begin
      check("cmd_ready", bus.cmd_ready, m_cmd_ready);
      check("in_ready", bus.in_ready, m_pops_left > 0);
      check("res_valid", bus.res_valid, m_emit);
      check("busy", bus.busy, (m_pops_left > 0) || m_emit);
      if (m_emit) begin
        check("res_data", bus.res_data, m_res);
`ifdef MYGO_SUM_READER_OVF_EN
        check("res_ovf", bus.res_ovf, m_ovf);
`endif
      end
      if (bus.in_ready) ir_cnt++;
      if (m_emit) begin
        if (bus.res_ready) begin
          m_emit      = 1'b0;
          m_cmd_ready = 1'b1;
        end
      end else if (m_pops_left > 0) begin
        if (bus.in_valid) begin
          m_pops_left--;
          if (m_pops_left == 0) m_emit = 1'b1;
        end
      end else if (m_cmd_ready && bus.cmd_valid) begin
        m_n   = int'(bus.cmd_data);
        m_tot = 0;
        for (int i = 0; i < m_n; i++)
          if (i < fifo_q.size()) m_tot += longint'(fifo_q[i]);
        m_res       = m_tot[31:0];
        m_ovf       = (m_tot >> 32) != 0;
        m_cmd_ready = 1'b0;
        if (m_n == 0) m_emit = 1'b1;
        else m_pops_left = m_n;
      end else begin
        m_cmd_ready = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    pop    = bus.in_valid & bus.in_ready;
    hs_cmd = bus.cmd_valid & bus.cmd_ready;
    hs_res = bus.res_valid & bus.res_ready;
    if (hs_res) begin
      got_res = bus.res_data;
`ifdef MYGO_SUM_READER_OVF_EN
      got_ovf = bus.res_ovf;
`else
      got_ovf = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    if (pop) begin
      tmp = fifo_q.pop_front();
      pops_total++;
    end
    refresh();
  endtask

  task automatic send_cmd(input int n);
    bit ok;
    ok = 1'b0;
    bus.cmd_data  = CB'(n);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (hs_cmd) begin
        ok = 1'b1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", ok, 1);
  endtask

  task automatic wait_res();
    bit ok;
    ok = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (hs_res) begin
        ok = 1'b1;
        break;
      end
    end
    bus.res_ready = 1'b0;
    check("res_handshake", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pops0;
    logic [0:5] pat;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b0;
    refresh();
    #1 rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();

    // n=4, back-to-back 1,2,3,4
    fifo_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    gate = 1'b1;
    refresh();
    ir_cnt = 0;
    send_cmd(4);
    wait_res();
    check("t1_sum", got_res, 10);
    check("t1_in_ready_cycles", ir_cnt, 4);
    cyc();
    check("t1_busy_after", bus.busy, 0);
    check("t1_cmd_ready_after", bus.cmd_ready, 1);

    // n=0
    ir_cnt = 0;
    send_cmd(0);
    check("t2_res_valid_next", bus.res_valid, 1);
    wait_res();
    check("t2_sum", got_res, 0);
    check("t2_no_pop", ir_cnt, 0);
    check("t2_cmd_ready_after", bus.cmd_ready, 1);

    // n=3 with gated supply, surplus word stays; then result back-pressure
    gate = 1'b0;
    fifo_q = '{32'd5, 32'd7, 32'd9, 32'd11};
    refresh();
    send_cmd(3);
    pops0 = pops_total;
    ir_cnt = 0;
    pat = 6'b100101;
    for (int i = 0; i < 6; i++) begin
      gate = pat[i];
      refresh();
      cyc();
    end
    gate = 1'b1;
    refresh();
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = CB'(1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_no_cmd_accept", hs_cmd, 0);
      check("t4_res_hold", bus.res_data, 21);
    end
    check("t3_pops", pops_total - pops0, 3);
    check("t3_in_ready_cycles", ir_cnt, 6);
    wait_res();
    check("t3_sum", got_res, 21);
    check("t3_surplus_left", fifo_q.size(), 1);
    send_cmd(1);
    wait_res();
    check("t3_surplus_sum", got_res, 11);

    // wrap-around and sticky carry
    fifo_q = '{32'hFFFF_FFFF, 32'h0000_0002, 32'd1, 32'd1};
    refresh();
    send_cmd(2);
    wait_res();
    check("t5_wrap_sum", got_res, 1);
`ifdef MYGO_SUM_READER_OVF_EN
    check("t5_ovf_set", got_ovf, 1);
`endif
    send_cmd(2);
    wait_res();
    check("t5_next_sum", got_res, 2);
`ifdef MYGO_SUM_READER_OVF_EN
    check("t5_ovf_clear", got_ovf, 0);
`endif

    // reset after 2 of 4 beats
    fifo_q = '{32'd100, 32'd200, 32'd300, 32'd400};
    refresh();
    send_cmd(4);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("t6_in_ready_rst", bus.in_ready, 0);
    check("t6_busy_rst", bus.busy, 0);
    check("t6_cmd_ready_rst", bus.cmd_ready, 0);
    check("t6_res_valid_rst", bus.res_valid, 0);
    check("t6_unpopped", fifo_q.size(), 2);
    fifo_q.delete();
    fifo_q = '{32'd8, 32'd8};
    refresh();
    cyc();
    cyc();
    rst = 1'b1;
    send_cmd(2);
    wait_res();
    check("t6_sum_after_reset", got_res, 16);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mygo_chan_sum_reader.md
# mygo_chan_sum_reader

Receive-side endpoint for a `mygo_fifo` channel: drains a commanded number of words from a FIFO's output port (`out_data`/`out_valid`/`out_ready`), accumulates them, and returns the sum on a result channel. It is the hardware image of a Go `for i := 0; i < n; i++ { s += <-ch }` loop. It sits between a FIFO instance and a downstream consumer stage, all using the same valid/ready channel protocol.

## Interface
Parameters:
- `WIDTH`, 32 — data and accumulator width in bits.
- `CNT_BITS`, 16 — width of the element-count command.

Ports:
- Reset and clock: one clock; reset is asynchronous and active-low.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `cmd_data` input `CNT_BITS` — number of words to receive, n; 0 is legal.
- `cmd_valid` input 1 — command offered.
- `cmd_ready` output 1 — command accepted when high with `cmd_valid`.
- `in_data` input `WIDTH` — word from the FIFO `out_data`.
- `in_valid` input 1 — from the FIFO `out_valid`.
- `in_ready` output 1 — to the FIFO `out_ready`.
- `res_data` output `WIDTH` — sum of the received words.
- `res_valid` output 1 — result offered.
- `res_ready` input 1 — result consumed when high with `res_valid`.
- `busy` output 1 — high in RECV or EMIT.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`:
    - latch `remaining`=n and clear `acc`.
    - next state is RECV if n≠0, else EMIT with `res_data`=0.
  - RECV: `in_ready`=1. On each beat (`in_valid & in_ready`):
    - `acc` ← `acc` + `in_data`, modulo 2^WIDTH; carry is discarded.
    - `remaining` ← `remaining` − 1.
    - The beat with `remaining`==1 moves to EMIT.
  - EMIT: `res_valid`=1 and `res_data`=`acc`, held stable until `res_ready`. On the handshake, go to IDLE.
- `in_ready` and `cmd_ready` are decoded from state only, with no combinational path from any input.
- `in_ready` is never high outside RECV, so no word beyond n is ever popped. Surplus words stay in the FIFO for the next command.
- `in_valid` low in RECV is a stall: no state change, wait indefinitely.
- Reset mid-operation:
  - Abandons the transaction. The partial sum is lost and no result is emitted.
  - Words already popped are gone; unpopped words remain in the FIFO.

## Timing
- Reset values: state=IDLE, `acc`=0, `remaining`=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `busy`=0.
- `cmd_ready` is forced 0 while `rst` is low and is 1 from the first cycle after release.
- Command accepted in cycle t → `in_ready`=1 in cycle t+1. For n=0, `res_valid`=1 in cycle t+1 instead.
- Throughput: one word per cycle in RECV when `in_valid` is held high. n words take n cycles at minimum.
- Last beat in cycle t → `res_valid`=1 with the final sum in cycle t+1.
- Result handshake in cycle t → `cmd_ready`=1 in cycle t+1. This gives at least one dead cycle between transactions.
- `res_data` is stable and `res_valid` is not withdrawn while `res_ready` is low.
- Minimum transaction period: n+2 cycles.

## Configuration
- `MYGO_SUM_READER_OVF_EN` defined:
  - Adds output `res_ovf` (1 bit, reset 0), valid alongside `res_data`.
  - It is a sticky flag set when any accumulation in the transaction produces an unsigned carry out of bit `WIDTH-1`.
  - It is cleared on command accept.
- Not defined: the port and its logic are absent. Wrap-around is silent and all other behaviour is identical.

## Test plan
- Reset, then command n=4, FIFO supplies 1,2,3,4 back-to-back → `in_ready` high for exactly 4 cycles; `res_valid`=1 one cycle after the last beat; `res_data`=10; `busy` drops after the result handshake.
- Command n=0 → no `in_ready` pulse; `res_valid`=1 with `res_data`=0 the next cycle; `cmd_ready`=1 the cycle after `res_ready`.
- n=3 with `in_valid` toggling 1,0,0,1,0,1 carrying 5,7,9 → exactly 3 pops; `res_data`=21; a fourth word queued in the FIFO is not popped.
- `res_ready` held low for 5 cycles in EMIT → `res_valid` and `res_data` stay stable; `cmd_valid` is not accepted until after the result handshake.
- With `WIDTH`=32, n=2, words 0xFFFFFFFF and 0x00000002 → `res_data`=0x00000001; `res_ovf`=1 only with `MYGO_SUM_READER_OVF_EN`; the next transaction of 1+1 gives `res_ovf`=0.
- Assert `rst` low after 2 of 4 beats → outputs return to reset values immediately; after release, command n=2 with 8,8 → `res_data`=16.
